// File: rtl/sm_rom_loader.sv
// Byte-stream program loader: assembles little-endian words from a length-prefixed
// stream and writes them into instruction memory, holding the CPU in reset meanwhile.
module sm_rom_loader #(
  parameter int unsigned SIZE    = 64,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned IW = $clog2(SIZE) + 1;
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [16:0]   SIZE_W   = 17'(SIZE);

  typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StWrite} state_e;

  state_e         r_state;
  logic [7:0]     r_len_lo;
  logic [IW-1:0]  r_len;
  logic [IW-1:0]  r_idx;
  logic [1:0]     r_bidx;
  logic [23:0]    r_buf;
  logic [TW-1:0]  r_tmo;
  logic           r_we;
  logic [31:0]    r_wa;
  logic [31:0]    r_wd;
  logic           r_cpu_rst_n;
  logic           r_busy;
  logic           r_done;
  logic           r_error;

  logic           w_receiving;
  logic           w_xfer;
  logic           w_tmo_hit;
  logic [15:0]    w_len;
  logic [IW-1:0]  w_idx_nxt;

  assign w_receiving = (r_state == StLenLo) || (r_state == StLenHi) || (r_state == StData);
  assign byte_ready  = w_receiving;
  assign w_xfer      = byte_valid & w_receiving;
  assign w_len       = {byte_data, r_len_lo};
  assign w_idx_nxt   = r_idx + 1'b1;
  // Fires on the TIMEOUT-th consecutive cycle without a transfer.
  assign w_tmo_hit   = (TIMEOUT != 0) && w_receiving && !w_xfer && (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_len_lo    <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_bidx      <= '0;
      r_buf       <= '0;
      r_tmo       <= '0;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_cpu_rst_n <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_we <= 1'b0;

      if (w_receiving && !w_xfer) begin
        r_tmo <= r_tmo + 1'b1;
      end else begin
        r_tmo <= '0;
      end

      if (w_tmo_hit) begin
        // Abort keeps the CPU in reset; words already written are left in place.
        r_state <= StIdle;
        r_busy  <= 1'b0;
        r_error <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (load_start) begin
              r_state     <= StLenLo;
              r_busy      <= 1'b1;
              r_cpu_rst_n <= 1'b0;
              r_done      <= 1'b0;
              r_error     <= 1'b0;
              r_idx       <= '0;
              r_bidx      <= '0;
            end
          end
          StLenLo: begin
            if (w_xfer) begin
              r_len_lo <= byte_data;
              r_state  <= StLenHi;
            end
          end
          StLenHi: begin
            if (w_xfer) begin
              if (w_len == 16'd0) begin
                r_state     <= StIdle;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_cpu_rst_n <= 1'b1;
              end else if ({1'b0, w_len} > SIZE_W) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
                r_error <= 1'b1;
              end else begin
                r_len   <= w_len[IW-1:0];
                r_state <= StData;
              end
            end
          end
          StData: begin
            if (w_xfer) begin
              r_bidx <= r_bidx + 1'b1;
              unique case (r_bidx)
                2'd0: r_buf[7:0]   <= byte_data;
                2'd1: r_buf[15:8]  <= byte_data;
                2'd2: r_buf[23:16] <= byte_data;
                2'd3: begin
                  r_we    <= 1'b1;
                  r_wa    <= {{(30 - IW){1'b0}}, r_idx, 2'b00};
                  r_wd    <= {byte_data, r_buf};
                  r_state <= StWrite;
                end
                default: ;
              endcase
            end
          end
          StWrite: begin
            r_idx <= w_idx_nxt;
            if (w_idx_nxt == r_len) begin
              r_state     <= StIdle;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_state <= StData;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign we        = r_we;
  assign wa        = r_wa;
  assign wd        = r_wd;
  assign cpu_rst_n = r_cpu_rst_n;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_sm_rom_loader.sv
// Self-checking bench for sm_rom_loader: a stream-level model predicts each imem write
// and the final status; a monitor checks every write strobe against it.
module tb_sm_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, we, cpu_rst_n, busy, done, error;
  logic [31:0] wa, wd;

  always #5 clk = ~clk;

  sm_rom_loader #(.SIZE(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .we(we), .wa(wa), .wd(wd),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_wa_q[$];
  logic [31:0] exp_wd_q[$];
  logic [31:0] log_wa[$];
  logic [31:0] log_wd[$];
  logic [7:0]  stream[$];
  logic        exp_done, exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next predicted write.
  always @(negedge clk) begin
    if (rst_n && we) begin
      log_wa.push_back(wa);
      log_wd.push_back(wd);
      if (exp_wa_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_we: got wa=%0h wd=%0h expected no write", wa, wd);
      end else begin
        chk("we_wa", wa, exp_wa_q.pop_front());
        chk("we_wd", wd, exp_wd_q.pop_front());
      end
      chk("ready_low_in_write", 32'(byte_ready), 32'd0);
    end
  end

  // Stream-level model: predicted writes for every complete word, and final status.
  task automatic model_load(input logic [7:0] q[$], output logic d, output logic e);
    int n;
    d = 1'b0;
    e = 1'b1;
    if (q.size() < 2) return;
    n = int'(q[0]) + 256 * int'(q[1]);
    if (n == 0) begin
      d = 1'b1;
      e = 1'b0;
    end else if (n <= 64) begin
      for (int w = 0; w < n; w++) begin
        if (q.size() >= 2 + 4 * w + 4) begin
          exp_wa_q.push_back(32'(4 * w));
          exp_wd_q.push_back({q[2+4*w+3], q[2+4*w+2], q[2+4*w+1], q[2+4*w]});
        end
      end
      d = (q.size() >= 2 + 4 * n);
      e = !d;
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("start_done", 32'(done), 32'd0);
    chk("start_error", 32'(error), 32'd0);
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input bit gaps);
    int g;
    foreach (q[i]) begin
      if (gaps) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      byte_valid = 1'b1;
      byte_data  = q[i];
      g = 0;
      while (!byte_ready && g < 50) begin @(posedge clk); #1; g++; end
      if (!byte_ready) begin
        n_checks++;
        n_errors++;
        $display("FAIL ready_wait: got ready=0 after %0d cycles expected 1", g);
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int limit);
    int g = 0;
    while (busy && g < limit) begin @(posedge clk); #1; g++; end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", g);
    end
  endtask

  task automatic finish_load(input string name, input logic d, input logic e);
    wait_idle(100);
    repeat (2) begin @(posedge clk); #1; end
    chk({name, "_done"}, 32'(done), 32'(d));
    chk({name, "_error"}, 32'(error), 32'(e));
    chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(d));
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_pending_writes"}, 32'(exp_wa_q.size()), 32'd0);
  endtask

  task automatic run_load(input string name, input logic [7:0] q[$], input bit gaps);
    logic d, e;
    log_wa.delete();
    log_wd.delete();
    model_load(q, d, e);
    start_load();
    send_bytes(q, gaps);
    finish_load(name, d, e);
  endtask

  initial begin
    #12;
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_wa", wa, 32'd0);
    chk("rst_wd", wd, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word program, back-to-back bytes; literal write log pins the model.
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    run_load("basic", stream, 1'b0);
    chk("basic_nwrites", 32'(log_wa.size()), 32'd2);
    if (log_wa.size() >= 2) begin
      chk("basic_wa0", log_wa[0], 32'h0);
      chk("basic_wd0", log_wd[0], 32'h0000_0013);
      chk("basic_wa1", log_wa[1], 32'h4);
      chk("basic_wd1", log_wd[1], 32'h0000_006F);
    end

    // Same stream with random valid gaps.
    run_load("gappy", stream, 1'b1);
    chk("gappy_nwrites", 32'(log_wa.size()), 32'd2);

    // Mixed-byte words check lane ordering.
    stream = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'hFF, 8'h00,
               8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("lanes", stream, 1'b1);
    if (log_wd.size() >= 3) chk("lanes_wd2", log_wd[2], 32'hDEAD_BEEF);

    // Oversize image (65 words > 64).
    stream = '{8'h41, 8'h00};
    run_load("oversize", stream, 1'b0);
    chk("oversize_nwrites", 32'(log_wa.size()), 32'd0);

    // Exactly SIZE words would be accepted; spot-check boundary length via LEN_HI byte.
    stream = '{8'h00, 8'h01};
    run_load("oversize_hi", stream, 1'b0);

    // Timeout: stall after one data byte.
    log_wa.delete();
    log_wd.delete();
    stream = '{8'h01, 8'h00, 8'hAA};
    model_load(stream, exp_done, exp_err);
    start_load();
    send_bytes(stream, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    chk("tmo_still_busy", 32'(busy), 32'd1);
    finish_load("timeout", exp_done, exp_err);
    chk("timeout_nwrites", 32'(log_wa.size()), 32'd0);

    // Full valid load recovers from the failed one.
    stream = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load("recover", stream, 1'b0);
    if (log_wd.size() >= 1) chk("recover_wd0", log_wd[0], 32'h0010_0093);

    // Zero-length image completes immediately.
    stream = '{8'h00, 8'h00};
    run_load("zero", stream, 1'b0);
    chk("zero_nwrites", 32'(log_wa.size()), 32'd0);

    // load_start while busy must not restart the load.
    log_wa.delete();
    log_wd.delete();
    stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    model_load(stream, exp_done, exp_err);
    start_load();
    stream = '{8'h01, 8'h00, 8'h11};
    send_bytes(stream, 1'b0);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    stream = '{8'h22, 8'h33, 8'h44};
    send_bytes(stream, 1'b0);
    finish_load("nostart", exp_done, exp_err);
    if (log_wd.size() >= 1) chk("nostart_wd0", log_wd[0], 32'h4433_2211);

    // Asynchronous reset mid-load returns everything to reset values.
    start_load();
    stream = '{8'h02, 8'h00, 8'h55, 8'h66};
    send_bytes(stream, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(byte_ready), 32'd0);
    chk("midrst_wa", wa, 32'd0);
    chk("midrst_wd", wd, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("midrst_idle_ready", 32'(byte_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
